// File: rtl/oai21_exhaustive_bist.sv
// Exhaustive BIST for LANES parallel OAI21 cells: sweeps all 8 {A1,A2,B} vectors PASSES times
// and checks ZN = !((A1|A2)&B), reporting a per-lane fail mask, error count and first failing vector.
module oai21_exhaustive_bist #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned PASSES = 2,
   parameter int unsigned SETTLE = 1
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   output logic [LANES-1:0] A1,
   output logic [LANES-1:0] A2,
   output logic [LANES-1:0] B,
   input  logic [LANES-1:0] ZN,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [LANES-1:0] FAIL_LANE,
   output logic [7:0]       ERR_CNT,
   output logic [2:0]       FIRST_ERR_VEC
);

   localparam int unsigned VEC_W  = 3;
   localparam int unsigned PASS_W = 8;
   localparam int unsigned SET_W  = 4;
   localparam int unsigned ERR_W  = 8;
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [PASS_W-1:0]  pass_q, pass_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [LANES-1:0]   a1_d, a2_d, b_d, fail_d;
   logic [ERR_W-1:0]   err_d;
   logic [VEC_W-1:0]   first_d;
   logic               busy_d, done_d, pass_flag_d;
   logic               load_vec;
   logic [LANES-1:0]   exp_zn, mis;
   logic [VEC_W-1:0]   lv;

   // Next-state, result update and drive-vector generation
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      pass_d   = pass_q;
      settle_d = settle_q;
      a1_d     = A1;
      a2_d     = A2;
      b_d      = B;
      fail_d   = FAIL_LANE;
      err_d    = ERR_CNT;
      first_d  = FIRST_ERR_VEC;
      load_vec = 1'b0;
      lv       = '0;
      exp_zn   = '0;
      mis      = '0;

      // X/Z on a returned ZN must count as a failure, hence the case inequality
      for (int unsigned i = 0; i < LANES; i++) begin
         exp_zn[i] = ~((A1[i] | A2[i]) & B[i]);
         mis[i]    = (ZN[i] !== exp_zn[i]);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               fail_d   = '0;
               err_d    = '0;
               first_d  = '0;
               vec_d    = '0;
               pass_d   = '0;
               settle_d = '0;
               load_vec = 1'b1;
               state_d  = (SETTLE == 0) ? S_SAMPLE : S_APPLY;
            end
         end
         S_APPLY: begin
            if (settle_q == SET_W'(SETTLE - 1)) begin
               settle_d = '0;
               state_d  = S_SAMPLE;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         S_SAMPLE: begin
            if (|mis) begin
               if (ERR_CNT != ERR_MAX) err_d = ERR_CNT + ERR_W'(1);
               if (ERR_CNT == '0)      first_d = vec_q;
            end
            fail_d = FAIL_LANE | mis;
            vec_d  = vec_q + VEC_W'(1);
            if (vec_q == VEC_W'(7)) pass_d = pass_q + PASS_W'(1);
            if (vec_q == VEC_W'(7) && pass_q == PASS_W'(PASSES - 1)) begin
               state_d = S_DONE;
               a1_d    = '0;
               a2_d    = '0;
               b_d     = '0;
            end else begin
               load_vec = 1'b1;
               state_d  = (SETTLE == 0) ? S_SAMPLE : S_APPLY;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Lane i sees vec ^ i so neighbouring lanes never share a pattern
      if (load_vec) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            lv      = vec_d ^ VEC_W'(i);
            a1_d[i] = lv[2];
            a2_d[i] = lv[1];
            b_d[i]  = lv[0];
         end
      end

      busy_d      = (state_d == S_APPLY) || (state_d == S_SAMPLE);
      done_d      = (state_d == S_DONE);
      pass_flag_d = done_d && (err_d == '0);
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q       <= S_IDLE;
         vec_q         <= '0;
         pass_q        <= '0;
         settle_q      <= '0;
         A1            <= '0;
         A2            <= '0;
         B             <= '0;
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
         PASS          <= 1'b0;
         FAIL_LANE     <= '0;
         ERR_CNT       <= '0;
         FIRST_ERR_VEC <= '0;
      end else begin
         state_q       <= state_d;
         vec_q         <= vec_d;
         pass_q        <= pass_d;
         settle_q      <= settle_d;
         A1            <= a1_d;
         A2            <= a2_d;
         B             <= b_d;
         BUSY          <= busy_d;
         DONE          <= done_d;
         PASS          <= pass_flag_d;
         FAIL_LANE     <= fail_d;
         ERR_CNT       <= err_d;
         FIRST_ERR_VEC <= first_d;
      end
   end

endmodule

// File: tb/tb_oai21_exhaustive_bist.sv
// Bench for oai21_exhaustive_bist: three configurations, ideal/faulty/delayed cell models,
// randomized per-sample fault injection checked against a schedule-walking reference model.
module tb_oai21_exhaustive_bist;

   localparam int unsigned L = 4;
   localparam int unsigned A_PASSES = 2;
   localparam int unsigned A_SETTLE = 1;
   localparam int unsigned A_SAMPLES = 8 * A_PASSES;
   localparam int unsigned A_CYC = A_SAMPLES * (A_SETTLE + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rn;

   int checks = 0;
   int failures = 0;

   function automatic logic [L-1:0] oai(input logic [L-1:0] a1, input logic [L-1:0] a2,
                                        input logic [L-1:0] b);
      return ~((a1 | a2) & b);
   endfunction

   // instance a: LANES=4 PASSES=2 SETTLE=1, ZN = ideal ^ injected errors, optional stuck-at-0
   logic a_start, a_busy, a_done, a_pass;
   logic [L-1:0] a_a1, a_a2, a_b, a_zn, a_fail, a_inj, a_stuck0;
   logic [7:0] a_err;
   logic [2:0] a_first;
   assign a_zn = (oai(a_a1, a_a2, a_b) ^ a_inj) & ~a_stuck0;

   oai21_exhaustive_bist #(.LANES(L), .PASSES(A_PASSES), .SETTLE(A_SETTLE)) u_a (
      .CLK(clk), .RN(rn), .START(a_start), .A1(a_a1), .A2(a_a2), .B(a_b), .ZN(a_zn),
      .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .FAIL_LANE(a_fail), .ERR_CNT(a_err),
      .FIRST_ERR_VEC(a_first));

   // instance b: PASSES=32 SETTLE=0, lane0 inverted or 2-cycle delayed cell
   logic b_start, b_busy, b_done, b_pass, b_mode;
   logic [L-1:0] b_a1, b_a2, b_b, b_zn, b_fail, b_d1, b_d2;
   logic [7:0] b_err;
   logic [2:0] b_first;
   assign b_zn = b_mode ? b_d2 : (oai(b_a1, b_a2, b_b) ^ 4'b0001);

   oai21_exhaustive_bist #(.LANES(L), .PASSES(32), .SETTLE(0)) u_b (
      .CLK(clk), .RN(rn), .START(b_start), .A1(b_a1), .A2(b_a2), .B(b_b), .ZN(b_zn),
      .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .FAIL_LANE(b_fail), .ERR_CNT(b_err),
      .FIRST_ERR_VEC(b_first));

   // instance c: PASSES=2 SETTLE=3, 2-cycle delayed cell
   logic c_start, c_busy, c_done, c_pass;
   logic [L-1:0] c_a1, c_a2, c_b, c_zn, c_fail, c_d1, c_d2;
   logic [7:0] c_err;
   logic [2:0] c_first;
   assign c_zn = c_d2;

   oai21_exhaustive_bist #(.LANES(L), .PASSES(2), .SETTLE(3)) u_c (
      .CLK(clk), .RN(rn), .START(c_start), .A1(c_a1), .A2(c_a2), .B(c_b), .ZN(c_zn),
      .BUSY(c_busy), .DONE(c_done), .PASS(c_pass), .FAIL_LANE(c_fail), .ERR_CNT(c_err),
      .FIRST_ERR_VEC(c_first));

   always @(posedge clk) begin
      b_d1 <= oai(b_a1, b_a2, b_b);
      b_d2 <= b_d1;
      c_d1 <= oai(c_a1, c_a2, c_b);
      c_d2 <= c_d1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [L-1:0] inj_tab [A_SAMPLES];

   task automatic chk_a_zero(input string tag);
      chk({tag, "_a1"}, 32'(a_a1), 0);
      chk({tag, "_a2"}, 32'(a_a2), 0);
      chk({tag, "_b"}, 32'(a_b), 0);
      chk({tag, "_busy"}, 32'(a_busy), 0);
      chk({tag, "_done"}, 32'(a_done), 0);
      chk({tag, "_pass"}, 32'(a_pass), 0);
      chk({tag, "_fail"}, 32'(a_fail), 0);
      chk({tag, "_err"}, 32'(a_err), 0);
      chk({tag, "_first"}, 32'(a_first), 0);
   endtask

   // One run on instance a; abort_at>=0 pulls reset at that cycle, glitch_at>=0 re-pulses START
   task automatic run_a(input int abort_at, input int glitch_at);
      int nerr;
      logic [L-1:0] fexp, mis, ea1, ea2, eb;
      logic [2:0] fv, v, lv;
      logic e, z;
      nerr = 0; fexp = '0; fv = '0;
      for (int s = 0; s < int'(A_SAMPLES); s++) begin
         v = 3'(s % 8);
         mis = '0;
         for (int i = 0; i < int'(L); i++) begin
            lv = v ^ 3'(i);
            e = ~((lv[2] | lv[1]) & lv[0]);
            z = (e ^ inj_tab[s][i]) & ~a_stuck0[i];
            mis[i] = (z != e);
         end
         if (mis != '0) begin
            if (nerr == 0) fv = v;
            if (nerr < 255) nerr++;
         end
         fexp |= mis;
      end

      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int k = 0; k < int'(A_CYC); k++) begin
         int s;
         s = k / int'(A_SETTLE + 1);
         if (k == abort_at) begin
            rn = 1'b0;
            #1;
            chk_a_zero("abort");
            @(posedge clk); #1;
            rn = 1'b1;
            a_inj = '0;
            repeat (3) begin
               @(posedge clk); #1;
               chk("abort_idle_busy", 32'(a_busy), 0);
               chk("abort_idle_done", 32'(a_done), 0);
            end
            return;
         end
         for (int i = 0; i < int'(L); i++) begin
            lv = 3'(s) ^ 3'(i);
            ea1[i] = lv[2]; ea2[i] = lv[1]; eb[i] = lv[0];
         end
         chk("run_busy", 32'(a_busy), 1);
         chk("run_done", 32'(a_done), 0);
         chk("run_drive", {20'd0, a_a1, a_a2, a_b}, {20'd0, ea1, ea2, eb});
         if (k == 0) begin
            chk("start_clr_err", 32'(a_err), 0);
            chk("start_clr_fail", 32'(a_fail), 0);
            chk("start_pass", 32'(a_pass), 0);
         end
         a_inj = inj_tab[s];
         a_start = (k == glitch_at);
         @(posedge clk); #1;
      end
      a_start = 1'b0;
      a_inj = '0;
      chk("end_done", 32'(a_done), 1);
      chk("end_busy", 32'(a_busy), 0);
      chk("end_pass", 32'(a_pass), 32'(nerr == 0));
      chk("end_err", 32'(a_err), 32'(nerr));
      chk("end_fail", 32'(a_fail), 32'(fexp));
      if (nerr != 0) chk("end_first", 32'(a_first), 32'(fv));
      chk("end_drive", {20'd0, a_a1, a_a2, a_b}, 0);
   endtask

   task automatic run_b(input logic mode);
      b_mode = mode;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      for (int k = 0; k < 256; k++) begin
         chk("b_busy", 32'(b_busy), 1);
         @(posedge clk); #1;
      end
      chk("b_done", 32'(b_done), 1);
      chk("b_pass", 32'(b_pass), 0);
      if (!mode) begin
         chk("b_err_sat", 32'(b_err), 255);
         chk("b_fail", 32'(b_fail), 32'h1);
         chk("b_first", 32'(b_first), 0);
      end else begin
         chk("b_err_nonzero", 32'(b_err != 0), 1);
      end
   endtask

   task automatic run_c();
      c_start = 1'b1;
      @(posedge clk); #1;
      c_start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         chk("c_busy", 32'(c_busy), 1);
         @(posedge clk); #1;
      end
      chk("c_done", 32'(c_done), 1);
      chk("c_pass", 32'(c_pass), 1);
      chk("c_err", 32'(c_err), 0);
      chk("c_fail", 32'(c_fail), 0);
   endtask

   initial begin
      rn = 1'b0;
      a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
      a_inj = '0; a_stuck0 = '0; b_mode = 1'b0;
      for (int s = 0; s < int'(A_SAMPLES); s++) inj_tab[s] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_a_zero("reset");
      rn = 1'b1;
      @(posedge clk); #1;

      // ideal cells
      run_a(-1, -1);

      // lane 2 stuck at 0
      a_stuck0 = 4'b0100;
      run_a(-1, -1);
      chk("stuck2_err", 32'(a_err), 10);
      chk("stuck2_fail", 32'(a_fail), 32'h4);
      chk("stuck2_first", 32'(a_first), 0);
      a_stuck0 = '0;

      // restart from DONE with errors pending, START glitch while busy
      run_a(-1, 5);

      // reset mid-run then a clean run
      run_a(10, -1);
      run_a(-1, -1);

      // randomized fault injection
      repeat (8) begin
         for (int s = 0; s < int'(A_SAMPLES); s++)
            inj_tab[s] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0;
         a_stuck0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
         run_a(-1, -1);
      end
      a_stuck0 = '0;

      run_b(1'b0);
      run_b(1'b1);
      run_c();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
